load_store_unit: RTL

Multicycle load/store engine sitting directly downstream of the processor control unit, between the datapath's address/data registers and the 64-bit data memory. On a one-cycle `start` command it performs one RV64I load (lb/lh/lw/ld/lbu/lhu/lwu) or store (sb/sh/sw/sd) over a ready-handshaked doubleword memory bus. Loads are extracted and sign- or zero-extended; sub-doubleword stores use read-modify-write. One `done` pulse is issued per accepted command, and the MDR / register file consumes it.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Doubleword data-memory bus between the load/store engine (master) and memory (slave).
// The master holds address, data and write enable steady until the slave returns ready.
interface load_store_unit_if #(
   parameter int ADDR_W = 64
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV64I load/store engine: one command per start strobe, sub-doubleword
// stores done as read-modify-write over a ready-handshaked doubleword bus.
module load_store_unit #(
   parameter int ADDR_W = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                is_store,
   input  logic [2:0]          funct3,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [63:0]         store_data,
   output logic                busy,
   output logic                done,
   output logic                fault,
   output logic [63:0]         load_data,
   load_store_unit_if.master   mem
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

   state_t            state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [2:0]        off_q, off_d;
   logic [63:0]       store_data_q, store_data_d;
   logic              fault_q, fault_d;
   logic [63:0]       load_data_q, load_data_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]       wdata_q, wdata_d;

   logic              misaligned;
   logic              cmd_fault;
   logic [63:0]       rdata_sh;
   logic [63:0]       extracted;
   logic [63:0]       sdata_sh;
   logic [3:0]        size_bytes;
   logic [7:0]        byte_en;
   logic [63:0]       merged;

   // Command check runs on the raw inputs so a bad command can go straight to FINISH.
   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         2'b11:   misaligned = |addr[2:0];
         default: misaligned = 1'b0;
      endcase
      cmd_fault = misaligned | (is_store ? funct3[2] : (funct3 == 3'b111));
   end

   assign rdata_sh = mem.mem_rdata >> {off_q, 3'b000};

   always_comb begin
      extracted = rdata_sh;
      case (funct3_q)
         3'b000:  extracted = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
         3'b001:  extracted = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
         3'b010:  extracted = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
         3'b100:  extracted = {56'd0, rdata_sh[7:0]};
         3'b101:  extracted = {48'd0, rdata_sh[15:0]};
         3'b110:  extracted = {32'd0, rdata_sh[31:0]};
         default: extracted = rdata_sh;
      endcase
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   size_bytes = 4'd1;
         2'b01:   size_bytes = 4'd2;
         2'b10:   size_bytes = 4'd4;
         default: size_bytes = 4'd8;
      endcase
   end

   assign sdata_sh = store_data_q << {off_q, 3'b000};

   // Byte lanes off..off+size-1 take store data; every other lane keeps the read value.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign byte_en[gi] = (4'(gi) >= {1'b0, off_q}) &&
                              (4'(gi) <  ({1'b0, off_q} + size_bytes));
         assign merged[8*gi +: 8] = byte_en[gi] ? sdata_sh[8*gi +: 8]
                                                : mem.mem_rdata[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      store_data_d = store_data_q;
      fault_d      = fault_q;
      load_data_d  = load_data_q;
      mem_addr_d   = mem_addr_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               is_store_d   = is_store;
               funct3_d     = funct3;
               off_d        = addr[2:0];
               store_data_d = store_data;
               mem_addr_d   = {addr[ADDR_W-1:3], 3'b000};
               fault_d      = cmd_fault;
               if (cmd_fault) begin
                  state_d = FINISH;
               end else if (is_store && (funct3 == 3'b011)) begin
                  wdata_d = store_data;
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (mem.mem_ready) begin
               if (is_store_q) begin
                  wdata_d = merged;
                  state_d = WRITE;
               end else begin
                  load_data_d = extracted;
                  state_d     = FINISH;
               end
            end
         end
         WRITE: begin
            if (mem.mem_ready) begin
               state_d = FINISH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 3'd0;
         store_data_q <= 64'd0;
         fault_q      <= 1'b0;
         load_data_q  <= 64'd0;
         mem_addr_q   <= '0;
         wdata_q      <= 64'd0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         store_data_q <= store_data_d;
         fault_q      <= fault_d;
         load_data_q  <= load_data_d;
         mem_addr_q   <= mem_addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // Control outputs decode state only, so reset removes a request immediately.
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign fault         = (state_q == FINISH) && fault_q;
   assign load_data     = load_data_q;
   assign mem.mem_req   = (state_q == READ) || (state_q == WRITE);
   assign mem.mem_we    = (state_q == WRITE);
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule
